// File: rtl/spi_pkg.sv
// Shared definitions for the SPI register frame and the controller state machine.
package spi_pkg;

  localparam int FRAME_W  = 16;
  localparam int ADDR_W   = 7;
  localparam int DATA_W   = 8;
  localparam int RW_BIT   = 15;
  localparam int ADDR_MSB = 14;
  localparam int ADDR_LSB = 8;
  localparam int DATA_MSB = 7;
  localparam int DATA_LSB = 0;

  localparam logic [ADDR_W-1:0] MAX_ADDRESS = 7'h04;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT_HI,
    ST_SHIFT_LO,
    ST_HOLD,
    ST_GAP
  } ctrl_state_t;

  function automatic logic [FRAME_W-1:0] pack_frame(
    input logic              write,
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] data
  );
    logic [FRAME_W-1:0] frame;
    frame                      = '0;
    frame[RW_BIT]              = write;
    frame[ADDR_MSB:ADDR_LSB]   = addr;
    frame[DATA_MSB:DATA_LSB]   = data;
    return frame;
  endfunction

endpackage

// File: rtl/spi_ctrl_timer.sv
// Loadable 8-bit down-counter; parks at zero so the zero flag marks the last
// cycle of a setup, half-period, hold or gap interval.
module spi_ctrl_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] load_value,
  output logic       zero
);

  logic [7:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != 8'd0) begin
      count <= count - 8'd1;
    end
  end

  assign zero = (count == 8'd0);

endmodule

// File: rtl/spi_controller.sv
// SPI mode-0 initiator: shifts one 16-bit R/W + address + data frame per
// accepted command and returns the MISO byte captured during the data phase.
module spi_controller
  import spi_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int CS_IDLE  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rx_data,
  output logic              sclk,
  output logic              mosi,
  output logic              cs_n,
  input  logic              miso
);

  localparam logic [7:0] SETUP_LD = 8'(CS_SETUP - 1);
  localparam logic [7:0] HALF_LD  = 8'(CLK_DIV - 1);
  localparam logic [7:0] HOLD_LD  = 8'(CS_HOLD - 1);
  localparam logic [7:0] GAP_LD   = 8'(CS_IDLE - 1);

  ctrl_state_t        state;
  logic [FRAME_W-1:0] shift_reg;
  logic [FRAME_W-1:0] next_frame;
  logic [DATA_W-1:0]  rx_shift;
  logic [3:0]         bit_idx;
  logic               miso_meta;
  logic               miso_sync;
  logic               accept;
  logic               timer_load;
  logic [7:0]         timer_value;
  logic               timer_zero;

  assign accept     = cmd_valid && cmd_ready;
  assign next_frame = pack_frame(cmd_write, cmd_addr, cmd_data);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      miso_meta <= 1'b0;
      miso_sync <= 1'b0;
    end else begin
      miso_meta <= miso;
      miso_sync <= miso_meta;
    end
  end

  // Each interval is loaded with its length minus one on the edge that enters it.
  always_comb begin
    timer_load  = 1'b0;
    timer_value = '0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          timer_load  = 1'b1;
          timer_value = SETUP_LD;
        end
      end
      ST_SETUP, ST_SHIFT_LO: begin
        if (timer_zero) begin
          timer_load  = 1'b1;
          timer_value = HALF_LD;
        end
      end
      ST_SHIFT_HI: begin
        if (timer_zero) begin
          timer_load  = 1'b1;
          timer_value = (bit_idx == 4'd0) ? HOLD_LD : HALF_LD;
        end
      end
      ST_HOLD: begin
        if (timer_zero) begin
          timer_load  = 1'b1;
          timer_value = GAP_LD;
        end
      end
      default: begin
      end
    endcase
  end

  spi_ctrl_timer u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (timer_load),
    .load_value (timer_value),
    .zero       (timer_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cs_n      <= 1'b1;
      sclk      <= 1'b0;
      mosi      <= 1'b0;
      cmd_ready <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rx_data   <= '0;
      shift_reg <= '0;
      rx_shift  <= '0;
      bit_idx   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          cmd_ready <= 1'b1;
          if (accept) begin
            shift_reg <= next_frame;
            mosi      <= next_frame[RW_BIT];
            cs_n      <= 1'b0;
            sclk      <= 1'b0;
            busy      <= 1'b1;
            cmd_ready <= 1'b0;
            bit_idx   <= 4'(FRAME_W - 1);
            state     <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (timer_zero) begin
            sclk  <= 1'b1;
            state <= ST_SHIFT_HI;
          end
        end
        ST_SHIFT_HI: begin
          if (timer_zero) begin
            sclk <= 1'b0;
            if (bit_idx == 4'd0) begin
              state <= ST_HOLD;
            end else begin
              shift_reg <= shift_reg << 1;
              mosi      <= shift_reg[RW_BIT-1];
              bit_idx   <= bit_idx - 4'd1;
              state     <= ST_SHIFT_LO;
            end
          end
        end
        ST_SHIFT_LO: begin
          // Rising edge: the responder's data byte occupies bit indices 7..0.
          if (timer_zero) begin
            sclk  <= 1'b1;
            state <= ST_SHIFT_HI;
            if (bit_idx <= 4'(DATA_MSB)) begin
              rx_shift <= {rx_shift[DATA_W-2:0], miso_sync};
            end
          end
        end
        ST_HOLD: begin
          if (timer_zero) begin
            cs_n    <= 1'b1;
            done    <= 1'b1;
            rx_data <= rx_shift;
            mosi    <= 1'b0;
            state   <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (timer_zero) begin
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_controller.sv
// Bench for spi_controller: a behavioural SPI register responder on the bus,
// a default-timing instance and a minimum-timing instance sharing it.
module tb_spi_controller;
  import spi_pkg::*;

  typedef struct {
    logic        sel;
    logic        write;
    logic [6:0]  addr;
    logic [7:0]  data;
    logic [7:0]  miso;
    logic [15:0] exp_frame;
    logic [7:0]  exp_rx;
    logic        check_rx;
    int          exp_cs_low;
    int          exp_gap;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n = 1'b0;
  logic       sel = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_write = 1'b0;
  logic [6:0] cmd_addr = '0;
  logic [7:0] cmd_data = '0;
  logic       miso = 1'b0;

  logic       cmd_valid_a, cmd_ready_a, busy_a, done_a, sclk_a, mosi_a, cs_n_a;
  logic       cmd_valid_b, cmd_ready_b, busy_b, done_b, sclk_b, mosi_b, cs_n_b;
  logic [7:0] rx_data_a, rx_data_b;

  assign cmd_valid_a = cmd_valid & ~sel;
  assign cmd_valid_b = cmd_valid & sel;

  spi_controller dut_a (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid_a), .cmd_ready(cmd_ready_a),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .busy(busy_a), .done(done_a), .rx_data(rx_data_a),
    .sclk(sclk_a), .mosi(mosi_a), .cs_n(cs_n_a), .miso(miso)
  );

  spi_controller #(.CLK_DIV(2), .CS_SETUP(1), .CS_HOLD(1), .CS_IDLE(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready_b),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .busy(busy_b), .done(done_b), .rx_data(rx_data_b),
    .sclk(sclk_b), .mosi(mosi_b), .cs_n(cs_n_b), .miso(miso)
  );

  logic       bus_sclk, bus_mosi, bus_cs_n, cur_ready, cur_done;
  logic [7:0] cur_rx;
  assign bus_sclk  = sel ? sclk_b : sclk_a;
  assign bus_mosi  = sel ? mosi_b : mosi_a;
  assign bus_cs_n  = sel ? cs_n_b : cs_n_a;
  assign cur_ready = sel ? cmd_ready_b : cmd_ready_a;
  assign cur_done  = sel ? done_b : done_a;
  assign cur_rx    = sel ? rx_data_b : rx_data_a;

  // Responder: commits a write only for a complete 16-bit frame to a legal address.
  logic [15:0] resp_shift = '0;
  logic [15:0] last_frame = '0;
  logic [7:0]  miso_pattern = '0;
  logic [7:0]  regs [0:4];
  int          resp_bits = 0;
  int          last_bits = 0;
  int          frames_seen = 0;

  always @(negedge bus_cs_n) begin
    resp_bits  = 0;
    resp_shift = '0;
  end

  always @(posedge bus_sclk) begin
    if (bus_cs_n === 1'b0) begin
      resp_shift = {resp_shift[14:0], bus_mosi};
      resp_bits++;
    end
  end

  always @(negedge bus_sclk) begin
    if (bus_cs_n === 1'b0 && resp_bits >= 8 && resp_bits < 16)
      miso <= miso_pattern[15 - resp_bits];
  end

  always @(posedge bus_cs_n) begin
    last_frame = resp_shift;
    last_bits  = resp_bits;
    if (resp_bits == 16) begin
      frames_seen++;
      if (resp_shift[15] && resp_shift[14:8] <= MAX_ADDRESS)
        regs[int'(resp_shift[14:8])] = resp_shift[7:0];
    end
  end

  int         low_run = 0, high_run = 0, last_low = 0, last_high = 0, done_cnt = 0;
  logic [7:0] done_rx = '0;

  always @(negedge clk) begin
    if (bus_cs_n === 1'b0) begin
      if (high_run > 0) last_high = high_run;
      high_run = 0;
      low_run++;
    end else begin
      if (low_run > 0) last_low = low_run;
      low_run = 0;
      high_run++;
    end
    if (cur_done === 1'b1) begin
      done_cnt++;
      done_rx = cur_rx;
    end
  end

  int   checks = 0;
  int   failures = 0;
  int   done_before = 0;
  int   ready_gap = 0;
  vec_t vecs [5];

  task automatic compare(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic issueCommand(input logic write, input logic [6:0] addr, input logic [7:0] data);
    int guard;
    guard = 0;
    @(negedge clk);
    while (cur_ready !== 1'b1 && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    compare("ready_timeout", 32'(guard >= 1000), 32'd0);
    cmd_write = write;
    cmd_addr  = addr;
    cmd_data  = data;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic waitDone(output int gap);
    int guard;
    guard = 0;
    while (cur_done !== 1'b1 && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    compare("done_timeout", 32'(guard >= 2000), 32'd0);
    gap = 0;
    while (cur_ready !== 1'b1 && gap < 300) begin
      @(negedge clk);
      gap++;
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    sel          = v.sel;
    miso_pattern = v.miso;
    done_before  = done_cnt;
    issueCommand(v.write, v.addr, v.data);
    cmd_valid = 1'b0;
    cmd_write = ~v.write;
    cmd_addr  = v.addr ^ 7'h7F;
    cmd_data  = ~v.data;
    waitDone(ready_gap);
  endtask

  task automatic checkOutput(input vec_t v);
    #1;
    compare("mosi_frame", 32'(last_frame), 32'(v.exp_frame));
    compare("sclk_rises", 32'(last_bits), 32'd16);
    compare("cs_low_cycles", 32'(last_low), 32'(v.exp_cs_low));
    compare("done_pulses", 32'(done_cnt - done_before), 32'd1);
    compare("ready_gap", 32'(ready_gap), 32'(v.exp_gap));
    if (v.check_rx) compare("rx_data", 32'(done_rx), 32'(v.exp_rx));
  endtask

  initial begin
    int guard;
    int frames_before;
    vec_t v;
    for (int i = 0; i < 5; i++) regs[i] = 8'h00;

    vecs[0] = '{1'b0, 1'b1, 7'h00, 8'hA5, 8'h5A, 16'h80A5, 8'h5A, 1'b1, 128, 4};
    vecs[1] = '{1'b0, 1'b1, 7'h01, 8'h3C, 8'h96, 16'h813C, 8'h96, 1'b1, 128, 4};
    vecs[2] = '{1'b0, 1'b1, 7'h04, 8'h80, 8'h0F, 16'h8480, 8'h0F, 1'b1, 128, 4};
    vecs[3] = '{1'b0, 1'b1, 7'h05, 8'h11, 8'hF0, 16'h8511, 8'hF0, 1'b1, 128, 4};
    vecs[4] = '{1'b0, 1'b0, 7'h02, 8'h00, 8'hC3, 16'h0200, 8'hC3, 1'b1, 128, 4};

    repeat (3) @(negedge clk);
    compare("rst_cs_n", 32'(cs_n_a), 32'd1);
    compare("rst_sclk", 32'(sclk_a), 32'd0);
    compare("rst_mosi", 32'(mosi_a), 32'd0);
    compare("rst_ready", 32'(cmd_ready_a), 32'd0);
    compare("rst_busy", 32'(busy_a), 32'd0);
    compare("rst_done", 32'(done_a), 32'd0);
    compare("rst_rx", 32'(rx_data_a), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    compare("idle_ready", 32'(cmd_ready_a), 32'd1);

    for (int i = 0; i < 5; i++) begin
      applyStimulus(vecs[i]);
      checkOutput(vecs[i]);
    end
    compare("reg0", 32'(regs[0]), 32'h A5);
    compare("reg1", 32'(regs[1]), 32'h3C);
    compare("reg2", 32'(regs[2]), 32'h00);
    compare("reg3", 32'(regs[3]), 32'h00);
    compare("reg4", 32'(regs[4]), 32'h80);
    compare("frames", 32'(frames_seen), 32'd5);

    // Two queued commands with cmd_valid never dropped.
    frames_before = frames_seen;
    done_before   = done_cnt;
    issueCommand(1'b1, 7'h01, 8'h11);
    cmd_addr = 7'h02;
    cmd_data = 8'h22;
    guard = 0;
    while (cur_ready !== 1'b1 && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    compare("b2b_timeout", 32'(guard >= 2000), 32'd0);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    waitDone(ready_gap);
    #1;
    compare("b2b_cs_high", 32'(last_high), 32'd5);
    compare("b2b_frames", 32'(frames_seen - frames_before), 32'd2);
    compare("b2b_done", 32'(done_cnt - done_before), 32'd2);
    compare("b2b_reg1", 32'(regs[1]), 32'h11);
    compare("b2b_reg2", 32'(regs[2]), 32'h22);

    // Reset after seven SCLK rises aborts the frame.
    frames_before = frames_seen;
    done_before   = done_cnt;
    issueCommand(1'b1, 7'h03, 8'h77);
    cmd_valid = 1'b0;
    guard = 0;
    while (resp_bits != 7 && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    compare("abort_timeout", 32'(guard >= 2000), 32'd0);
    rst_n = 1'b0;
    #1;
    compare("abort_cs_n", 32'(cs_n_a), 32'd1);
    compare("abort_sclk", 32'(sclk_a), 32'd0);
    compare("abort_busy", 32'(busy_a), 32'd0);
    repeat (3) @(negedge clk);
    compare("abort_done", 32'(done_cnt - done_before), 32'd0);
    compare("abort_frames", 32'(frames_seen - frames_before), 32'd0);
    compare("abort_reg3", 32'(regs[3]), 32'h00);
    rst_n = 1'b1;

    v = '{1'b0, 1'b1, 7'h00, 8'h42, 8'h81, 16'h8042, 8'h81, 1'b1, 128, 4};
    applyStimulus(v);
    checkOutput(v);
    compare("post_reset_reg0", 32'(regs[0]), 32'h42);

    // Minimum-timing instance.
    v = '{1'b1, 1'b1, 7'h03, 8'hFF, 8'h00, 16'h83FF, 8'h00, 1'b0, 64, 3};
    applyStimulus(v);
    checkOutput(v);
    compare("min_reg3", 32'(regs[3]), 32'hFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
